// File: rtl/serial_adder_display_pkg.sv
// Shared types and constants for the serial adder display demo.
// Holds the sequencer state encoding and active-low seven-segment patterns.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package serial_adder_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the arithmetic core of the bit-serial adder.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // Sum and majority carry.
    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

// File: rtl/serial_adder_display_seg7_decoder.sv
// BCD nibble to active-low seven-segment pattern; non-decimal codes blank the digit.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module seg7_decoder
    import serial_adder_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup; codes 10..15 never come out of a valid BCD digit, so show nothing.
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/serial_adder_display.sv
// Bit-serial adder, double-dabble BCD converter and multiplexed 7-seg driver (macro LEADING_ZERO_BLANK_EN blanks leading zeros).
// Latency: done pulses 2*WIDTH+2 cycles after the accepted start edge.
// Backpressure: start is ignored while busy; nothing is queued.
module serial_adder_display
    import serial_adder_display_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  sum,
    output logic              cout,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int BW = 4 * DIGITS;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_sh_q, sum_sh_d;
    logic              carry_q, carry_d;
    logic [WIDTH:0]    bin_q, bin_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              ovf_run_q, ovf_run_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic [BW-1:0]     disp_q, disp_d;
    logic              ovf_q, ovf_d;
    logic [RW-1:0]     refresh_q, refresh_d;
    logic [SW-1:0]     scan_q, scan_d;

    logic              fa_s, fa_c;
    logic [BW-1:0]     bcd_adj, bcd_step;
    logic [WIDTH:0]    bin_step;
    logic              step_ovf;
    logic [3:0]        nibble;
    logic [6:0]        dec_seg;

    full_adder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    seg7_decoder u_dec (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    // One double-dabble step: add 3 to every nibble >= 5, then shift binary MSB into BCD.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        step_ovf = bcd_adj[BW-1];
        bcd_step = {bcd_adj[BW-2:0], bin_q[WIDTH]};
        bin_step = {bin_q[WIDTH-1:0], 1'b0};
    end

    // Sequencer next state; CONV spends its first cycle loading the adder result, then WIDTH+1 shifts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        carry_d   = carry_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_run_d = ovf_run_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_ADD;
                end
            end
            ST_ADD: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_c;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (cnt_q == '0) begin
                    bin_d     = {carry_q, sum_sh_q};
                    bcd_d     = '0;
                    ovf_run_d = 1'b0;
                    cnt_d     = 1'b1;
                end else begin
                    bin_d     = bin_step;
                    bcd_d     = bcd_step;
                    ovf_run_d = ovf_run_q | step_ovf;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH + 1)) begin
                        sum_d   = sum_sh_q;
                        cout_d  = carry_q;
                        disp_d  = bcd_step;
                        ovf_d   = ovf_run_q | step_ovf;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer, datapath and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            ovf_run_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            carry_q   <= carry_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            ovf_run_q <= ovf_run_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
        end
    end

    // Free-running digit scan, independent of the sequencer.
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        scan_d    = scan_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            scan_d    = (scan_q == SW'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
        end
    end

    // Scan counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            scan_q    <= '0;
        end else begin
            refresh_q <= refresh_d;
            scan_q    <= scan_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_nz;

    // Pick the scanned digit and note whether it or any higher digit is non-zero.
    always_comb begin
        nibble   = 4'd0;
        upper_nz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (SW'(i) == scan_q) begin
                nibble = disp_q[4*i +: 4];
            end
            if ((SW'(i) >= scan_q) && (disp_q[4*i +: 4] != 4'd0)) begin
                upper_nz = 1'b1;
            end
        end
    end

    // Dashes on overflow win; otherwise leading zeros above digit 0 go dark.
    always_comb begin
        an = ~(DIGITS'(1) << scan_q);
        if (ovf_q) begin
            seg = SEG_DASH;
        end else if ((scan_q != '0) && !upper_nz) begin
            seg = SEG_BLANK;
        end else begin
            seg = dec_seg;
        end
    end
`else
    // Pick the scanned digit.
    always_comb begin
        nibble = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (SW'(i) == scan_q) begin
                nibble = disp_q[4*i +: 4];
            end
        end
    end

    // Dashes on overflow, otherwise every digit shown including zeros.
    always_comb begin
        an  = ~(DIGITS'(1) << scan_q);
        seg = ovf_q ? SEG_DASH : dec_seg;
    end
`endif

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_display.sv
// Directed bench for serial_adder_display: an 8-bit instance and a 12-bit overflow instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected sums, latencies and segment patterns are worked out by hand below.
module tb_serial_adder_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic [6:0]  seg8;
    logic [2:0]  an8;

    logic        start12 = 1'b0, cin12 = 1'b0;
    logic [11:0] a12 = '0, b12 = '0;
    logic        busy12, done12, cout12;
    logic [11:0] sum12;
    logic [6:0]  seg12;
    logic [2:0]  an12;

    int checks = 0;
    int errors = 0;

    serial_adder_display #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .seg(seg8), .an(an8)
    );

    serial_adder_display #(.WIDTH(12), .DIGITS(3), .REFRESH_DIV(4)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .a(a12), .b(b12), .cin(cin12),
        .busy(busy12), .done(done12), .sum(sum12), .cout(cout12), .seg(seg12), .an(an12)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] UPPER_ZERO = 7'b1111111;
`else
    localparam logic [6:0] UPPER_ZERO = 7'b1000000;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then count edges until done (-1 if it never comes).
    task automatic run_op(input bit sel, input logic [11:0] av, input logic [11:0] bv,
                          input logic cv, output int lat);
        if (sel) begin
            a12 = av; b12 = bv; cin12 = cv; start12 = 1'b1;
        end else begin
            a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; start8 = 1'b1;
        end
        tick();
        start8  = 1'b0;
        start12 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if ((sel ? done12 : done8) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Watch a full scan rotation and capture the pattern shown on each digit.
    task automatic read_digits(input bit sel, output logic [6:0] d0, output logic [6:0] d1,
                               output logic [6:0] d2);
        logic [2:0] an_s;
        logic [6:0] sg;
        d0 = 7'bx; d1 = 7'bx; d2 = 7'bx;
        for (int i = 0; i < 16; i++) begin
            tick();
            an_s = sel ? an12 : an8;
            sg   = sel ? seg12 : seg8;
            case (an_s)
                3'b110: d0 = sg;
                3'b101: d1 = sg;
                3'b011: d2 = sg;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done8); end
        checks++; if (sum8 !== 8'd0) begin errors++; $display("FAIL reset_sum got %0d want 0", sum8); end
        checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout8); end
        checks++; if (seg8 !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b want 1000000", seg8); end
        checks++; if (an8 !== 3'b110) begin errors++; $display("FAIL reset_an got %b want 110", an8); end
        rst = 1'b0;
    endtask

    // 200 + 100 + 1 = 301 -> sum 301-256 = 45, cout 1, digits 3 0 1.
    task automatic test_add_301();
        int lat;
        logic [6:0] d0, d1, d2;
        run_op(1'b0, 12'd200, 12'd100, 1'b1, lat);
        checks++; if (lat != 18) begin errors++; $display("FAIL add301_latency got %0d want 18", lat); end
        checks++; if (sum8 !== 8'd45) begin errors++; $display("FAIL add301_sum got %0d want 45", sum8); end
        checks++; if (cout8 !== 1'b1) begin errors++; $display("FAIL add301_cout got %b want 1", cout8); end
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL add301_busy_in_done got %b want 1", busy8); end
        tick();
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL add301_done_width got %b want 0", done8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL add301_idle_busy got %b want 0", busy8); end
        read_digits(1'b0, d0, d1, d2);
        checks++; if (d0 !== 7'b1111001) begin errors++; $display("FAIL add301_digit0 got %b want 1111001", d0); end
        checks++; if (d1 !== 7'b1000000) begin errors++; $display("FAIL add301_digit1 got %b want 1000000", d1); end
        checks++; if (d2 !== 7'b0110000) begin errors++; $display("FAIL add301_digit2 got %b want 0110000", d2); end
    endtask

    task automatic test_zero();
        int lat;
        logic [6:0] d0, d1, d2;
        run_op(1'b0, 12'd0, 12'd0, 1'b0, lat);
        checks++; if (lat != 18) begin errors++; $display("FAIL zero_latency got %0d want 18", lat); end
        checks++; if ({cout8, sum8} !== 9'd0) begin errors++; $display("FAIL zero_result got %0d want 0", {cout8, sum8}); end
        read_digits(1'b0, d0, d1, d2);
        checks++; if (d0 !== 7'b1000000) begin errors++; $display("FAIL zero_digit0 got %b want 1000000", d0); end
        checks++; if (d1 !== UPPER_ZERO) begin errors++; $display("FAIL zero_digit1 got %b want %b", d1, UPPER_ZERO); end
        checks++; if (d2 !== UPPER_ZERO) begin errors++; $display("FAIL zero_digit2 got %b want %b", d2, UPPER_ZERO); end
    endtask

    // 10 + 20 = 30 with extra start pulses at +3 and +15 that must be dropped.
    task automatic test_ignore_start();
        int ndone = 0, first = -1, busy_low = 0;
        a8 = 8'd10; b8 = 8'd20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        for (int i = 1; i <= 40; i++) begin
            start8 = (i == 3 || i == 15);
            tick();
            if (done8 === 1'b1) begin
                ndone++;
                if (first < 0) first = i;
            end
            if (i < 18 && busy8 !== 1'b1) busy_low++;
        end
        start8 = 1'b0;
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        checks++; if (first != 18) begin errors++; $display("FAIL ignore_latency got %0d want 18", first); end
        checks++; if (busy_low != 0) begin errors++; $display("FAIL ignore_busy_drop got %0d cycles want 0", busy_low); end
        checks++; if (sum8 !== 8'd30) begin errors++; $display("FAIL ignore_sum got %0d want 30", sum8); end
    endtask

    // Abort a 50 + 60 operation 12 edges in (CONV) and check the result registers clear.
    task automatic test_reset_conv();
        int ndone = 0;
        logic [6:0] d0, d1, d2;
        a8 = 8'd50; b8 = 8'd60; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done8); end
        checks++; if (sum8 !== 8'd0) begin errors++; $display("FAIL abort_sum got %0d want 0", sum8); end
        checks++; if (an8 !== 3'b110) begin errors++; $display("FAIL abort_an got %b want 110", an8); end
        checks++; if (seg8 !== 7'b1000000) begin errors++; $display("FAIL abort_seg got %b want 1000000", seg8); end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done8 === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", ndone); end
        read_digits(1'b0, d0, d1, d2);
        checks++; if (d0 !== 7'b1000000) begin errors++; $display("FAIL abort_digit0 got %b want 1000000", d0); end
        checks++; if (d2 !== UPPER_ZERO) begin errors++; $display("FAIL abort_digit2 got %b want %b", d2, UPPER_ZERO); end
    endtask

    // 4095 + 4095 = 8190 -> sum 4094, cout 1, too big for 3 digits so all dashes.
    task automatic test_width12_ovf();
        int lat, k;
        logic [2:0] prev, cur, nxt;
        logic [6:0] d0, d1, d2;
        run_op(1'b1, 12'd4095, 12'd4095, 1'b0, lat);
        checks++; if (lat != 26) begin errors++; $display("FAIL w12_latency got %0d want 26", lat); end
        checks++; if (sum12 !== 12'd4094) begin errors++; $display("FAIL w12_sum got %0d want 4094", sum12); end
        checks++; if (cout12 !== 1'b1) begin errors++; $display("FAIL w12_cout got %b want 1", cout12); end
        read_digits(1'b1, d0, d1, d2);
        checks++; if (d0 !== 7'b0111111) begin errors++; $display("FAIL w12_digit0 got %b want 0111111", d0); end
        checks++; if (d1 !== 7'b0111111) begin errors++; $display("FAIL w12_digit1 got %b want 0111111", d1); end
        checks++; if (d2 !== 7'b0111111) begin errors++; $display("FAIL w12_digit2 got %b want 0111111", d2); end
        prev = an12;
        k = 0;
        while (k < 10 && an12 === prev) begin
            tick();
            k++;
        end
        checks++;
        if (an12 === prev) begin
            errors++;
            $display("FAIL w12_scan_timeout an stuck at %b", an12);
        end else begin
            for (int s = 0; s < 3; s++) begin
                cur = an12;
                nxt = {cur[1:0], cur[2]};
                for (int c = 0; c < 3; c++) tick();
                checks++; if (an12 !== cur) begin errors++; $display("FAIL w12_scan_hold got %b want %b", an12, cur); end
                tick();
                checks++; if (an12 !== nxt) begin errors++; $display("FAIL w12_scan_step got %b want %b", an12, nxt); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_301();
        test_zero();
        test_ignore_start();
        test_reset_conv();
        test_width12_ovf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
